axil_arbiter_2to1: RTL



---
 rtl/axil_arbiter_2to1.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : axil_arbiter_2to1
// Description : Two-to-one AXI4-Lite arbiter. The write and read paths are
//               arbitrated independently and each holds its grant until its
//               response handshake. AXIL_ARB_FIXED_PRIO_EN selects fixed
//               priority (port 0 wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_arbiter_2to1 #(
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              areset,
    // upstream port 0
    input  logic              s0_awvalid_i,
    output logic              s0_awready_o,
    input  logic [ADDR_W-1:0] s0_awaddr_i,
    input  logic [2:0]        s0_awprot_i,
    input  logic              s0_wvalid_i,
    output logic              s0_wready_o,
    input  logic [31:0]       s0_wdata_i,
    input  logic [3:0]        s0_wstrb_i,
    output logic              s0_bvalid_o,
    input  logic              s0_bready_i,
    output logic [1:0]        s0_bresp_o,
    input  logic              s0_arvalid_i,
    output logic              s0_arready_o,
    input  logic [ADDR_W-1:0] s0_araddr_i,
    input  logic [2:0]        s0_arprot_i,
    output logic              s0_rvalid_o,
    input  logic              s0_rready_i,
    output logic [31:0]       s0_rdata_o,
    output logic [1:0]        s0_rresp_o,
    // upstream port 1
    input  logic              s1_awvalid_i,
    output logic              s1_awready_o,
    input  logic [ADDR_W-1:0] s1_awaddr_i,
    input  logic [2:0]        s1_awprot_i,
    input  logic              s1_wvalid_i,
    output logic              s1_wready_o,
    input  logic [31:0]       s1_wdata_i,
    input  logic [3:0]        s1_wstrb_i,
    output logic              s1_bvalid_o,
    input  logic              s1_bready_i,
    output logic [1:0]        s1_bresp_o,
    input  logic              s1_arvalid_i,
    output logic              s1_arready_o,
    input  logic [ADDR_W-1:0] s1_araddr_i,
    input  logic [2:0]        s1_arprot_i,
    output logic              s1_rvalid_o,
    input  logic              s1_rready_i,
    output logic [31:0]       s1_rdata_o,
    output logic [1:0]        s1_rresp_o,
    // downstream port
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic [2:0]        m_awprot_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    output logic [31:0]       m_wdata_o,
    output logic [3:0]        m_wstrb_o,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    input  logic [1:0]        m_bresp_i,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [2:0]        m_arprot_o,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    input  logic [31:0]       m_rdata_i,
    input  logic [1:0]        m_rresp_i
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t wstate_q;
    rstate_t rstate_q;
    logic    wg_q, rg_q, aw_done_q, w_done_q;
    logic    aw_done_d, w_done_d, w_pick, r_pick;
    logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign w_pick = ~s0_awvalid_i;
    assign r_pick = ~s0_arvalid_i;
`else
    logic    wlast_q, rlast_q;
    // On a tie the port that did not finish last wins.
    assign w_pick = (s0_awvalid_i & s1_awvalid_i) ? ~wlast_q : s1_awvalid_i;
    assign r_pick = (s0_arvalid_i & s1_arvalid_i) ? ~rlast_q : s1_arvalid_i;
`endif

    assign aw_hs     = m_awvalid_o & m_awready_i;
    assign w_hs      = m_wvalid_o & m_wready_i;
    assign b_hs      = m_bvalid_i & m_bready_o;
    assign ar_hs     = m_arvalid_o & m_arready_i;
    assign r_hs      = m_rvalid_i & m_rready_o;
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            wg_q      <= 1'b0;
            rg_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            wlast_q   <= 1'b1;
            rlast_q   <= 1'b1;
`endif
        end else begin
            case (wstate_q)
                W_IDLE: if (s0_awvalid_i | s1_awvalid_i) begin
                    wg_q     <= w_pick;
                    wstate_q <= W_ADDR;
                end
                W_ADDR: if (aw_done_d & w_done_d) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    wstate_q  <= W_RESP;
                end else begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                end
                W_RESP: if (b_hs) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    wlast_q  <= wg_q;
`endif
                    wstate_q <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
            case (rstate_q)
                R_IDLE: if (s0_arvalid_i | s1_arvalid_i) begin
                    rg_q     <= r_pick;
                    rstate_q <= R_ADDR;
                end
                R_ADDR: if (ar_hs) rstate_q <= R_DATA;
                R_DATA: if (r_hs) begin
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    rlast_q  <= rg_q;
`endif
                    rstate_q <= R_IDLE;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        m_awvalid_o  = 1'b0;
        m_awaddr_o   = '0;
        m_awprot_o   = '0;
        m_wvalid_o   = 1'b0;
        m_wdata_o    = '0;
        m_wstrb_o    = '0;
        m_bready_o   = 1'b0;
        s0_awready_o = 1'b0;
        s1_awready_o = 1'b0;
        s0_wready_o  = 1'b0;
        s1_wready_o  = 1'b0;
        s0_bvalid_o  = 1'b0;
        s1_bvalid_o  = 1'b0;
        s0_bresp_o   = '0;
        s1_bresp_o   = '0;
        case (wstate_q)
            W_ADDR: begin
                m_awvalid_o  = (wg_q ? s1_awvalid_i : s0_awvalid_i) & ~aw_done_q;
                m_awaddr_o   = wg_q ? s1_awaddr_i : s0_awaddr_i;
                m_awprot_o   = wg_q ? s1_awprot_i : s0_awprot_i;
                m_wvalid_o   = (wg_q ? s1_wvalid_i : s0_wvalid_i) & ~w_done_q;
                m_wdata_o    = wg_q ? s1_wdata_i : s0_wdata_i;
                m_wstrb_o    = wg_q ? s1_wstrb_i : s0_wstrb_i;
                s0_awready_o = ~wg_q & m_awready_i & ~aw_done_q;
                s1_awready_o = wg_q & m_awready_i & ~aw_done_q;
                s0_wready_o  = ~wg_q & m_wready_i & ~w_done_q;
                s1_wready_o  = wg_q & m_wready_i & ~w_done_q;
            end
            W_RESP: begin
                m_bready_o  = wg_q ? s1_bready_i : s0_bready_i;
                s0_bvalid_o = ~wg_q & m_bvalid_i;
                s1_bvalid_o = wg_q & m_bvalid_i;
                s0_bresp_o  = wg_q ? 2'b00 : m_bresp_i;
                s1_bresp_o  = wg_q ? m_bresp_i : 2'b00;
            end
            default: ;
        endcase
    end

    always_comb begin
        m_arvalid_o  = 1'b0;
        m_araddr_o   = '0;
        m_arprot_o   = '0;
        m_rready_o   = 1'b0;
        s0_arready_o = 1'b0;
        s1_arready_o = 1'b0;
        s0_rvalid_o  = 1'b0;
        s1_rvalid_o  = 1'b0;
        s0_rdata_o   = '0;
        s1_rdata_o   = '0;
        s0_rresp_o   = '0;
        s1_rresp_o   = '0;
        case (rstate_q)
            R_ADDR: begin
                m_arvalid_o  = rg_q ? s1_arvalid_i : s0_arvalid_i;
                m_araddr_o   = rg_q ? s1_araddr_i : s0_araddr_i;
                m_arprot_o   = rg_q ? s1_arprot_i : s0_arprot_i;
                s0_arready_o = ~rg_q & m_arready_i;
                s1_arready_o = rg_q & m_arready_i;
            end
            R_DATA: begin
                m_rready_o  = rg_q ? s1_rready_i : s0_rready_i;
                s0_rvalid_o = ~rg_q & m_rvalid_i;
                s1_rvalid_o = rg_q & m_rvalid_i;
                s0_rdata_o  = rg_q ? 32'h0 : m_rdata_i;
                s1_rdata_o  = rg_q ? m_rdata_i : 32'h0;
                s0_rresp_o  = rg_q ? 2'b00 : m_rresp_i;
                s1_rresp_o  = rg_q ? m_rresp_i : 2'b00;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
